// File: rtl/cpu_package.sv
// Shared CPU definitions: word width, memory geometry and the memory-responder FSM states.
package cpu_package;

    localparam int unsigned WORD_WIDTH = 8;
    localparam int unsigned MEM_DEPTH  = 20;
    localparam int unsigned MEM_AW     = 5;

    typedef enum logic [1:0] {
        MsIdle = 2'd0,
        MsWait = 2'd1,
        MsResp = 2'd2
    } Type_mem_state;

endpackage

// File: rtl/mem_responder.sv
// Single-outstanding memory responder for the CPU fetch/load/store port:
// valid/ready request, fixed LAT wait cycles, valid/ready response.
module mem_responder
    import cpu_package::*;
#(
    parameter int unsigned DEPTH = MEM_DEPTH,
    parameter int unsigned LAT   = 2,
    parameter int unsigned AW    = MEM_AW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [AW-1:0]         req_addr,
    input  logic [WORD_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORD_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam logic [2:0] LAT_LOAD = 3'((LAT == 0) ? 0 : LAT - 1);

    Type_mem_state         r_state;
    Type_mem_state         w_state_nxt;
    logic [2:0]            r_cnt;
    logic [2:0]            w_cnt_nxt;

    logic                  r_we;
    logic                  r_err;
    logic [AW-1:0]         r_addr;
    logic [WORD_WIDTH-1:0] r_mem [DEPTH];
    logic [WORD_WIDTH-1:0] r_rdata;
    logic                  r_rsp_err;

    logic                  w_accept;
    logic                  w_req_err;
    logic                  w_enter_resp;
    logic                  w_sel_we;
    logic                  w_sel_err;
    logic [AW-1:0]         w_sel_addr;

    assign req_ready = (r_state == MsIdle) && !reset;
    assign rsp_valid = (r_state == MsResp);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_rsp_err;

    assign w_accept  = req_valid && req_ready;
    assign w_req_err = (32'(req_addr) >= DEPTH);

    // Next-state and latency counter
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            MsIdle: begin
                if (w_accept) begin
                    if (LAT == 0) begin
                        w_state_nxt = MsResp;
                    end else begin
                        w_state_nxt = MsWait;
                        w_cnt_nxt   = LAT_LOAD;
                    end
                end
            end
            MsWait: begin
                if (r_cnt == 3'd0) begin
                    w_state_nxt = MsResp;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            MsResp: begin
                if (rsp_ready) begin
                    w_state_nxt = MsIdle;
                end
            end
            default: begin
                w_state_nxt = MsIdle;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    // With LAT == 0 the response is loaded on the accepting edge, before the
    // request registers hold the new address, so take it from the inputs.
    always_comb begin
        w_enter_resp = (w_state_nxt == MsResp) && (r_state != MsResp);
        w_sel_we     = (r_state == MsIdle) ? req_we    : r_we;
        w_sel_err    = (r_state == MsIdle) ? w_req_err : r_err;
        w_sel_addr   = (r_state == MsIdle) ? req_addr  : r_addr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MsIdle;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Request capture, array write and response data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we      <= 1'b0;
            r_err     <= 1'b0;
            r_addr    <= '0;
            r_rdata   <= '0;
            r_rsp_err <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= WORD_WIDTH'(i);
            end
        end else begin
            if (w_accept) begin
                r_we   <= req_we;
                r_err  <= w_req_err;
                r_addr <= req_addr;
                if (req_we && !w_req_err) begin
                    r_mem[req_addr] <= req_wdata;
                end
            end
            if (w_enter_resp) begin
                r_rdata   <= (w_sel_we || w_sel_err) ? '0 : r_mem[w_sel_addr];
                r_rsp_err <= w_sel_err;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with LAT=2, one with LAT=0.
module tb_mem_responder;
    import cpu_package::*;

    logic       clk = 1'b0;
    logic       reset;
    int         vectors = 0;
    int         miscompares = 0;

    logic       req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [4:0] req_addr;
    logic [7:0] req_wdata, rsp_rdata;

    logic       z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [4:0] z_req_addr;
    logic [7:0] z_req_wdata, z_rsp_rdata;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(20), .LAT(2), .AW(5)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    mem_responder #(.DEPTH(20), .LAT(0), .AW(5)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    // One full transaction on the LAT=2 instance, starting at a negedge in MsIdle.
    task automatic xact(input logic we, input logic [4:0] addr, input logic [7:0] wd,
                        output logic [7:0] rd, output logic er, output int lat_n);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        lat_n = 1;
        while (!rsp_valid && lat_n < 20) begin
            @(negedge clk);
            lat_n++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        vectors += 4;
        if (req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
        if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        if (rsp_rdata !== 8'h00) begin miscompares++; $display("FAIL reset_rsp_rdata got %h want 00", rsp_rdata); end
        if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
        reset = 1'b0;
        @(negedge clk);
        vectors += 2;
        if (req_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_req_ready got %b want 1", req_ready); end
        if (z_req_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_req_ready_lat0 got %b want 1", z_req_ready); end
    endtask

    task automatic test_read_basic;
        logic [4:0] addrs [3];
        logic [7:0] rd;
        logic       er;
        int         n;
        addrs[0] = 5'd0; addrs[1] = 5'd7; addrs[2] = 5'd19;
        for (int k = 0; k < 3; k++) begin
            xact(1'b0, addrs[k], 8'h00, rd, er, n);
            vectors += 3;
            if (rd !== {3'b000, addrs[k]}) begin miscompares++; $display("FAIL read_rdata addr %0d got %h want %h", addrs[k], rd, {3'b000, addrs[k]}); end
            if (er !== 1'b0) begin miscompares++; $display("FAIL read_err addr %0d got %b want 0", addrs[k], er); end
            if (n != 3) begin miscompares++; $display("FAIL read_latency addr %0d got %0d want 3", addrs[k], n); end
        end
    endtask

    task automatic test_raw;
        logic [7:0] rd;
        logic       er;
        int         n;
        xact(1'b1, 5'd5, 8'h2A, rd, er, n);
        vectors += 3;
        if (rd !== 8'h00) begin miscompares++; $display("FAIL write_rdata got %h want 00", rd); end
        if (er !== 1'b0) begin miscompares++; $display("FAIL write_err got %b want 0", er); end
        if (n != 3) begin miscompares++; $display("FAIL write_latency got %0d want 3", n); end
        xact(1'b0, 5'd5, 8'h00, rd, er, n);
        vectors += 1;
        if (rd !== 8'h2A) begin miscompares++; $display("FAIL raw_rdata got %h want 2a", rd); end
    endtask

    task automatic test_err;
        logic [7:0] rd;
        logic       er;
        int         n;
        xact(1'b0, 5'd25, 8'h00, rd, er, n);
        vectors += 2;
        if (er !== 1'b1) begin miscompares++; $display("FAIL err_read_err got %b want 1", er); end
        if (rd !== 8'h00) begin miscompares++; $display("FAIL err_read_rdata got %h want 00", rd); end
        xact(1'b1, 5'd20, 8'h55, rd, er, n);
        vectors += 2;
        if (er !== 1'b1) begin miscompares++; $display("FAIL err_write_err got %b want 1", er); end
        if (rd !== 8'h00) begin miscompares++; $display("FAIL err_write_rdata got %h want 00", rd); end
        xact(1'b0, 5'd19, 8'h00, rd, er, n);
        vectors += 2;
        if (rd !== 8'd19) begin miscompares++; $display("FAIL err_after_rdata got %h want 13", rd); end
        if (er !== 1'b0) begin miscompares++; $display("FAIL err_after_err got %b want 0", er); end
    endtask

    task automatic test_stall;
        int n;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd7;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors += 1;
        if (n != 3) begin miscompares++; $display("FAIL stall_latency got %0d want 3", n); end
        for (int k = 0; k < 4; k++) begin
            vectors += 4;
            if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid cyc %0d got %b want 1", k, rsp_valid); end
            if (rsp_rdata !== 8'd7) begin miscompares++; $display("FAIL stall_rdata cyc %0d got %h want 07", k, rsp_rdata); end
            if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL stall_err cyc %0d got %b want 0", k, rsp_err); end
            if (req_ready !== 1'b0) begin miscompares++; $display("FAIL stall_req_ready cyc %0d got %b want 0", k, req_ready); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        vectors += 2;
        if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL stall_release_valid got %b want 0", rsp_valid); end
        if (req_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release_req_ready got %b want 1", req_ready); end
    endtask

    task automatic test_back_to_back;
        z_rsp_ready = 1'b1;
        z_req_valid = 1'b1; z_req_we = 1'b0; z_req_addr = 5'd1;
        vectors += 1;
        if (z_req_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready0 got %b want 1", z_req_ready); end
        @(posedge clk); @(negedge clk);
        vectors += 3;
        if (z_rsp_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid1 got %b want 1", z_rsp_valid); end
        if (z_rsp_rdata !== 8'd1) begin miscompares++; $display("FAIL b2b_rdata1 got %h want 01", z_rsp_rdata); end
        if (z_req_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready1 got %b want 0", z_req_ready); end
        z_req_addr = 5'd2;
        @(posedge clk); @(negedge clk);
        vectors += 2;
        if (z_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_gap_valid got %b want 0", z_rsp_valid); end
        if (z_req_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_gap_ready got %b want 1", z_req_ready); end
        @(posedge clk); @(negedge clk);
        vectors += 2;
        if (z_rsp_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid2 got %b want 1", z_rsp_valid); end
        if (z_rsp_rdata !== 8'd2) begin miscompares++; $display("FAIL b2b_rdata2 got %h want 02", z_rsp_rdata); end
        z_req_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        vectors += 1;
        if (z_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_end_valid got %b want 0", z_rsp_valid); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] rd;
        logic       er;
        int         n;
        xact(1'b1, 5'd3, 8'h3F, rd, er, n);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd3;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        vectors += 1;
        if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL mid_wait_valid got %b want 0", rsp_valid); end
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        vectors += 2;
        if (req_ready !== 1'b0) begin miscompares++; $display("FAIL mid_reset_ready got %b want 0", req_ready); end
        if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_valid got %b want 0", rsp_valid); end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors += 2;
            if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL mid_abandon_valid cyc %0d got %b want 0", k, rsp_valid); end
            if (req_ready !== 1'b1) begin miscompares++; $display("FAIL mid_after_ready cyc %0d got %b want 1", k, req_ready); end
        end
        xact(1'b0, 5'd3, 8'h00, rd, er, n);
        vectors += 2;
        if (rd !== 8'd3) begin miscompares++; $display("FAIL mid_reinit_rdata got %h want 03", rd); end
        if (n != 3) begin miscompares++; $display("FAIL mid_reinit_latency got %0d want 3", n); end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_rsp_ready = 1'b0;
        test_reset();
        test_read_basic();
        test_raw();
        test_err();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d vectors", vectors);
        $fatal(1);
    end

endmodule
